result_collector: RTL
=====================

Name: result_collector

Overview:
- HDL-side output transactor for the AES encoder/decoder bench. It is the return path that mirrors the input-pipe stimulus driver.
- Samples encoder and decoder outputs whenever either side's valid is high and tags each sample with a sequence number.
- Buffers the tagged records in a FIFO and streams them to an output-pipe adapter over a valid/ready handshake.
- On end-of-test it drains the FIFO, then sends a single end-of-message (EOM) summary beat, so HVL can score results instead of relying only on HDL assertions.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of 2 and at least 2.
- SEQ_W, 16: width of the sequence tag and of the record/drop counters.
- STATE_W, 128: AES state width. Equals the width of state_t.

Ports:
- clock  in  1  bench clock
- reset  in  1  reset, synchronous, active-high
- encrypt_valid  in  1  encoder output valid
- encrypt_data  in  STATE_W  encoder ciphertext
- decrypt_valid  in  1  decoder output valid
- decrypt_data  in  STATE_W  decoder plaintext
- end_of_test  in  1  single-cycle pulse: stimulus exhausted
- out_valid  out  1  record available to the pipe adapter
- out_ready  in  1  pipe adapter accepts the record
- out_data  out  SEQ_W+2*STATE_W+2  result_record_t
- out_eom  out  1  current beat is the EOM summary
- overflow  out  1  sticky: at least one record was dropped
- done  out  1  EOM accepted; collector idle

Behaviour:
- Reset values: out_valid=0, out_eom=0, out_data=0, overflow=0, done=0. Reset also clears the FIFO, the sequence counter, the drop counter and the record counter, and returns the FSM to COLLECT. Reset mid-operation discards all buffered records with no EOM sent.
- Record push:
  - A record is pushed in any cycle where (encrypt_valid | decrypt_valid) and the FSM is in COLLECT.
  - Record fields: {seq, encrypt_data, decrypt_data, enc_v=encrypt_valid, dec_v=decrypt_valid}.
  - The data field of an invalid side is forced to 0.
  - seq increments by 1 per push and wraps modulo 2^SEQ_W. The first record after reset has seq=0.
- Latency: a record pushed into an empty FIFO at edge N appears on out_valid after edge N+1, i.e. there is no bypass path.
- Handshake:
  - A transfer occurs at an edge where out_valid & out_ready.
  - out_data and out_eom hold stable while out_valid & !out_ready.
  - out_valid never deasserts without a transfer, except on reset.
- FIFO full:
  - A push while full and with no pop in the same cycle drops the record. The drop sets overflow and increments the drop counter, which saturates at all-ones.
  - The dropped record still consumes a seq value, so HVL can detect the gap.
  - Push and pop in the same cycle while full is legal; nothing is dropped.
- FIFO empty: out_valid=0 in COLLECT and DRAIN.
- FSM states:
  - COLLECT: accept pushes; stream records. Go to DRAIN on end_of_test.
  - DRAIN: no pushes; stream the remaining records. Go to EOM when the FIFO is empty and no transfer is pending.
  - EOM: out_valid=1, out_eom=1, out_data = {record count, drop count, zero-filled}, where record count is the number of records pushed. Go to DONE on out_ready.
  - DONE: done=1, out_valid=0. Input valids are ignored until reset.
- Simultaneous events:
  - Valid inputs in the same cycle as end_of_test are captured.
  - end_of_test outside COLLECT is ignored.
  - end_of_test with an empty FIFO goes DRAIN→EOM in consecutive cycles.
- Counters are SEQ_W wide. The record count excludes dropped records.

Decomposition:
- Add to the shared AESDefinitions package:
  - result_record_t (packed: seq, encrypt state_t, plain state_t, enc_v, dec_v).
  - collector_state_e {COLLECT, DRAIN, EOM, DONE}.
- One sub-module: sync_fifo, parameterised by type and DEPTH. It has registered output, full/empty flags and simultaneous push/pop support.
- FSM, counters and EOM muxing live in result_collector.

Test Plan:
- Reset, then encrypt_valid=1 with data 0x3925841d02dc09fbdc118597196a0b32 for 1 cycle, out_ready=1 → one beat: seq=0, enc_v=1, dec_v=0, plain=0; out_valid rises 2 edges after the push.
- Both valids high for 3 consecutive cycles, out_ready=0 for 5 cycles, then 1 → records seq 0,1,2 delivered in order with both flags set; out_data held stable while stalled.
- DEPTH=16, out_ready=0, 20 consecutive pushes → 16 stored; overflow=1; drop count=4; drained records carry seq 0..15; EOM reports record count=16, drop count=4.
- FIFO full with out_ready=1 and a push in the same cycle → no drop; overflow stays 0.
- 3 records buffered, end_of_test pulse together with a 4th valid → 4 records then EOM (count=4, drops=0); done=1; later valids are ignored.
- Reset asserted while in DRAIN with 5 records buffered → next cycle out_valid=0 and done=0; a new push gets seq=0.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared AES bench types: the tagged result record and the collector FSM encoding.
package result_collector_pkg;

  localparam int AES_STATE_W = 128;
  localparam int REC_SEQ_W   = 16;

  typedef logic [AES_STATE_W-1:0] state_t;

  typedef struct packed {
    logic [REC_SEQ_W-1:0] seq;
    state_t               encrypt;
    state_t               plain;
    logic                 enc_v;
    logic                 dec_v;
  } result_record_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EOM     = 2'd2,
    DONE    = 2'd3
  } collector_state_e;

  // EOM beat: record count in the seq slot, drop count directly below it.
  function automatic result_record_t make_eom(input logic [REC_SEQ_W-1:0] rec_cnt,
                                              input logic [REC_SEQ_W-1:0] drop_cnt);
    result_record_t r;
    r = '0;
    r.seq = rec_cnt;
    r.encrypt[AES_STATE_W-1 -: REC_SEQ_W] = drop_cnt;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered output stage; occupancy counts the output stage,
// so it holds exactly DEPTH items. Simultaneous push/pop when full is accepted.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_push,
  input  T     i_push_data,
  input  logic i_pop_ready,
  output logic o_valid,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_valid;
  T               r_data;

  logic           w_pop;
  logic           w_load;
  logic           w_push;
  logic [CW-1:0]  w_level;

  assign w_pop   = r_valid & i_pop_ready;
  // Refill the output stage from memory only; a same-cycle push never bypasses.
  assign w_load  = (r_count != '0) & (!r_valid | w_pop);
  assign w_level = r_count + CW'(r_valid);
  assign o_full  = (w_level == CW'(DEPTH));
  assign o_empty = (w_level == '0);
  assign w_push  = i_push & (!o_full | w_pop);
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_valid <= w_load | (r_valid & !w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_load);
    end
  end

endmodule

// File: rtl/result_collector.sv
// Output transactor: tags encoder/decoder results with a sequence number, buffers them,
// streams them over valid/ready and closes the stream with one EOM summary beat.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int SEQ_W   = REC_SEQ_W,
  parameter int STATE_W = AES_STATE_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_encrypt_valid,
  input  logic [STATE_W-1:0]         i_encrypt_data,
  input  logic                       i_decrypt_valid,
  input  logic [STATE_W-1:0]         i_decrypt_data,
  input  logic                       i_end_of_test,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [SEQ_W+2*STATE_W+1:0] o_out_data,
  output logic                       o_out_eom,
  output logic                       o_overflow,
  output logic                       o_done,
  output collector_state_e           o_state
);

  // Handshake: a beat transfers on a clock edge where o_out_valid & i_out_ready; while
  // o_out_valid is high without ready, o_out_data/o_out_eom hold and valid stays high.

  collector_state_e r_state;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_rec_cnt;
  logic [SEQ_W-1:0] r_drop_cnt;
  logic             r_overflow;
  logic             r_done;

  logic             w_push_req;
  logic             w_push;
  logic             w_drop;
  logic             w_fifo_valid;
  logic             w_fifo_pop;
  logic             w_full;
  logic             w_empty;
  result_record_t   w_record;
  result_record_t   w_fifo_data;

  assign w_push_req = (i_encrypt_valid | i_decrypt_valid) & (r_state == COLLECT);
  assign w_fifo_pop = w_fifo_valid & i_out_ready;
  assign w_drop     = w_push_req & w_full & !w_fifo_pop;
  assign w_push     = w_push_req & !w_drop;

  always_comb begin
    w_record         = '0;
    w_record.seq     = r_seq;
    w_record.encrypt = i_encrypt_valid ? i_encrypt_data : '0;
    w_record.plain   = i_decrypt_valid ? i_decrypt_data : '0;
    w_record.enc_v   = i_encrypt_valid;
    w_record.dec_v   = i_decrypt_valid;
  end

  sync_fifo #(
    .T     (result_record_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_record),
    .i_pop_ready (i_out_ready),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= COLLECT;
      r_seq      <= '0;
      r_rec_cnt  <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Dropped records still consume a tag so the gap is visible downstream.
      if (w_push_req) r_seq <= r_seq + SEQ_W'(1);
      if (w_push) r_rec_cnt <= r_rec_cnt + SEQ_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + SEQ_W'(1);
      end
      case (r_state)
        COLLECT: if (i_end_of_test) r_state <= DRAIN;
        DRAIN:   if (w_empty) r_state <= EOM;
        EOM: begin
          if (i_out_ready) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign o_out_valid = (r_state == EOM) | w_fifo_valid;
  assign o_out_eom   = (r_state == EOM);
  assign o_out_data  = (r_state == EOM) ? make_eom(r_rec_cnt, r_drop_cnt) : w_fifo_data;
  assign o_overflow  = r_overflow;
  assign o_done      = r_done;
  assign o_state     = r_state;

endmodule
